fifo_rd_stream: RTL and testbench

- Read-side drain engine for asyn_fifo: sits in the read clock domain and issues I_rinc-style pops into the FIFO read port (rinc/rdata/rempty).
- Re-times the FIFO's one-cycle read latency into a standard valid/ready stream for downstream logic.
- Sustains one word per cycle under continuous I_ready, with full backpressure.
- Counts delivered words.

---
 rtl/fifo_rd_stream_pkg.sv | 18 +
 rtl/fifo_rd_stream_if.sv | 33 +++
 rtl/fifo_rd_stream_skid.sv | 78 +++++++
 rtl/fifo_rd_stream.sv | 104 ++++++++++
 tb/tb_fifo_rd_stream.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the fifo_rd_stream read-side drain engine.
// Optional sequence checker is enabled with the FIFO_RD_SEQ_CHK_EN macro.
package fifo_rd_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned DSIZE_DEF = 8;

  typedef logic [1:0]           occ_t;
  typedef logic [DSIZE_DEF-1:0] data_t;

  localparam occ_t OCC_FULL = 2'(BUF_DEPTH);

  // Words buffered plus the one possibly returning from the FIFO read port.
  function automatic logic [2:0] pending(input occ_t occ, input logic inflight);
    return 3'(occ) + 3'(inflight);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for fifo_rd_stream.
interface fifo_rd_stream_if
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
);

  logic             O_rinc;
  logic [DSIZE-1:0] I_rdata;
  logic             I_rempty;
  logic             O_valid;
  logic [DSIZE-1:0] O_data;
  logic             I_ready;

  modport master (
    output O_rinc,
    input  I_rdata,
    input  I_rempty,
    output O_valid,
    output O_data,
    input  I_ready
  );

  modport slave (
    input  O_rinc,
    output I_rdata,
    output I_rempty,
    input  O_valid,
    input  O_data,
    output I_ready
  );

endinterface

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry in-order buffer: head drives the stream, tail absorbs the word
// returning from the FIFO while the head is still waiting to be accepted.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [DSIZE-1:0] data_o,
  output occ_t             occ_o
);

  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  occ_t             occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             pop_c, push_c;

  // Next-state: flush wins, otherwise shift/insert keeping strict FIFO order.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    pop_c   = pop_i && (occ_q != '0);
    push_c  = push_i && (pop_c || (occ_q != OCC_FULL));
    if (flush_i) begin
      occ_d = '0;
    end else begin
      unique case ({push_c, pop_c})
        2'b10: begin
          if (occ_q == '0) head_d = push_data_i;
          else             tail_d = push_data_i;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: begin
        end
      endcase
    end
    valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops asyn_fifo, re-times its one-cycle read latency
// into a valid/ready stream and counts delivered words.
// Optional sticky sequence checker: define FIFO_RD_SEQ_CHK_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned      DSIZE    = DSIZE_DEF,
  parameter int unsigned      CNT_W    = 16,
  parameter logic [DSIZE-1:0] SEQ_INIT = DSIZE'(1)
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_flush,
  fifo_rd_stream_if.master    bus,
  output logic [CNT_W-1:0]    O_rd_cnt,
  output logic                O_seq_err
);

  occ_t             occ;
  logic             skid_valid;
  logic [DSIZE-1:0] skid_data;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pend_c;
  logic             rinc_c;
  logic             accept_c;

  assign accept_c = skid_valid && bus.I_ready;

  // Pop only when the buffer can absorb the returning word, counting a
  // same-cycle downstream accept as freeing a slot.
  always_comb begin
    pend_c     = pending(occ, inflight_q);
    rinc_c     = I_rst_n && !bus.I_rempty && !I_flush &&
                 ((pend_c < 3'(BUF_DEPTH)) ||
                  (accept_c && (pend_c == 3'(BUF_DEPTH))));
    inflight_d = rinc_c;
    cnt_d      = accept_c ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  // A returning word is dropped inside the buffer when flush coincides with it.
  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk         (I_clk),
    .rst_n       (I_rst_n),
    .flush_i     (I_flush),
    .push_i      (inflight_q),
    .push_data_i (bus.I_rdata),
    .pop_i       (accept_c),
    .valid_o     (skid_valid),
    .data_o      (skid_data),
    .occ_o       (occ)
  );

  assign bus.O_rinc  = rinc_c;
  assign bus.O_valid = skid_valid;
  assign bus.O_data  = skid_data;
  assign O_rd_cnt    = cnt_q;

`ifdef FIFO_RD_SEQ_CHK_EN
  logic [DSIZE-1:0] exp_q, exp_d;
  logic             seq_err_q, seq_err_d;

  // Resync to the observed word so one gap reports once.
  always_comb begin
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    if (I_flush) begin
      exp_d = SEQ_INIT;
    end else if (accept_c) begin
      if (skid_data != exp_q) seq_err_d = 1'b1;
      exp_d = skid_data + DSIZE'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      exp_q     <= SEQ_INIT;
      seq_err_q <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign O_seq_err = seq_err_q;
`else
  logic unused_seq_init;
  assign unused_seq_init = ^SEQ_INIT;
  assign O_seq_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO read-port model,
// stream monitor and in-order word scoreboard.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rd_cnt;
  logic        seq_err;

  int checks = 0;
  int errors = 0;

  fifo_rd_stream_if #(.DSIZE(8)) bus ();

  fifo_rd_stream #(
    .DSIZE    (8),
    .CNT_W    (16),
    .SEQ_INIT (8'd1)
  ) dut (
    .I_clk     (clk),
    .I_rst_n   (rst_n),
    .I_flush   (flush),
    .bus       (bus),
    .O_rd_cnt  (rd_cnt),
    .O_seq_err (seq_err)
  );

  always #5 clk = ~clk;

  // FIFO read-port model: data appears the cycle after an accepted pop.
  logic [7:0] wr_q[$];
  logic [7:0] src_q[$];
  int         wr_idx   = 0;
  bit         wr_burst = 1'b1;
  int         wr_div   = 1;
  bit         s_pop    = 1'b0;

  always @(posedge clk) begin
    if (s_pop && src_q.size() > 0) bus.I_rdata <= src_q.pop_front();
    if (wr_burst) begin
      while (wr_idx < wr_q.size()) begin
        src_q.push_back(wr_q[wr_idx]);
        wr_idx++;
      end
    end else if (wr_idx < wr_q.size() &&
                 (wr_div <= 1 || $urandom_range(0, wr_div - 1) == 0)) begin
      src_q.push_back(wr_q[wr_idx]);
      wr_idx++;
    end
    bus.I_rempty <= (src_q.size() == 0);
  end

  // Stream monitor, sampled mid-cycle.
  int         cyc = 0;
  int         pop_total = 0, acc_total = 0;
  int         pop_empty_viol = 0, stab_viol = 0, outst_viol = 0;
  int         outst = 0;
  int         pop_cyc_q[$], acc_cyc_q[$], vrise_q[$], erise_q[$];
  logic [7:0] got_q[$];
  logic       p_valid = 1'b0, p_ready = 1'b0, p_flush = 1'b0, p_err = 1'b0;
  logic [7:0] p_data = 8'd0;

  always @(negedge clk) begin
    cyc++;
    s_pop = bus.O_rinc && !bus.I_rempty;
    if (!rst_n) begin
      outst   = 0;
      p_valid = 1'b0;
      p_ready = 1'b0;
      p_flush = 1'b0;
      p_err   = 1'b0;
    end else begin
      if (bus.O_rinc && bus.I_rempty) pop_empty_viol++;
      if (p_valid && !p_ready && !p_flush &&
          (bus.O_valid !== 1'b1 || bus.O_data !== p_data)) stab_viol++;
      if (bus.O_valid && !p_valid) vrise_q.push_back(cyc);
      if (seq_err && !p_err) erise_q.push_back(cyc);
      if (s_pop) begin
        pop_total++;
        pop_cyc_q.push_back(cyc);
      end
      if (bus.O_valid && bus.I_ready) begin
        acc_total++;
        acc_cyc_q.push_back(cyc);
        got_q.push_back(bus.O_data);
      end
      if (flush) outst = 0;
      else       outst = outst + int'(s_pop) - int'(bus.O_valid && bus.I_ready);
      if (outst > 2) outst_viol++;
      p_valid = bus.O_valid;
      p_ready = bus.I_ready;
      p_flush = flush;
      p_data  = bus.O_data;
      p_err   = seq_err;
    end
  end

  task automatic start_reset();
    rst_n       = 1'b0;
    flush       = 1'b0;
    bus.I_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic end_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (got_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    start_reset();
    wr_burst = 1'b1;
    for (int i = 1; i <= 30; i++) wr_q.push_back(8'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.O_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.O_valid); end
    checks++; if (bus.O_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", bus.O_data); end
    checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", rd_cnt); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    checks++; if (bus.O_rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b expected 0 with data waiting", bus.O_rinc); end
  endtask

  // 30 prefilled words, continuous ready: back-to-back pops and deliveries.
  task automatic test_stream();
    int b_got = got_q.size();
    int b_pop = pop_cyc_q.size();
    int b_acc = acc_cyc_q.size();
    int b_vr  = vrise_q.size();
    int span;
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus.I_ready = 1'b1;
    wait_got(b_got + 30, 200);
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() - b_got !== 30) begin errors++; $display("FAIL stream_count: got %0d words expected 30", got_q.size() - b_got); end
    for (int i = 0; i < 30 && b_got + i < got_q.size(); i++) begin
      checks++; if (got_q[b_got + i] !== 8'(i + 1)) begin errors++; $display("FAIL stream_word%0d: got %0d expected %0d", i, got_q[b_got + i], i + 1); end
    end
    checks++; if (pop_cyc_q.size() - b_pop !== 30) begin errors++; $display("FAIL stream_pops: got %0d expected 30", pop_cyc_q.size() - b_pop); end
    span = (pop_cyc_q.size() - b_pop == 30) ? pop_cyc_q[b_pop + 29] - pop_cyc_q[b_pop] : -1;
    checks++; if (span !== 29) begin errors++; $display("FAIL stream_pop_span: got %0d expected 29", span); end
    span = (acc_cyc_q.size() - b_acc == 30) ? acc_cyc_q[b_acc + 29] - acc_cyc_q[b_acc] : -1;
    checks++; if (span !== 29) begin errors++; $display("FAIL stream_out_span: got %0d expected 29", span); end
    span = (vrise_q.size() > b_vr && pop_cyc_q.size() > b_pop) ? vrise_q[b_vr] - pop_cyc_q[b_pop] : -1;
    checks++; if (span !== 2) begin errors++; $display("FAIL stream_latency: got %0d expected 2", span); end
    checks++; if (rd_cnt !== 16'd30) begin errors++; $display("FAIL stream_cnt: got %0d expected 30", rd_cnt); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL stream_seq_err: got %b expected 0", seq_err); end
    checks++; if (bus.O_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid: got %b expected 0", bus.O_valid); end
  endtask

  // Ready toggling every cycle: held words must stay stable, order kept.
  task automatic test_backpressure();
    logic [7:0] exp_w[$];
    int b_got, b_stab, b_out;
    start_reset();
    wr_burst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_w.push_back(8'($urandom));
      wr_q.push_back(exp_w[i]);
    end
    b_got  = got_q.size();
    b_stab = stab_viol;
    b_out  = outst_viol;
    end_reset();
    bus.I_ready = 1'b1;
    for (int k = 0; k < 400 && got_q.size() < b_got + 10; k++) begin
      @(posedge clk); #1;
      bus.I_ready = ~bus.I_ready;
    end
    bus.I_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() - b_got !== 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", got_q.size() - b_got); end
    for (int i = 0; i < 10 && b_got + i < got_q.size(); i++) begin
      checks++; if (got_q[b_got + i] !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d: got %0h expected %0h", i, got_q[b_got + i], exp_w[i]); end
    end
    checks++; if (stab_viol - b_stab !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable held words, expected 0", stab_viol - b_stab); end
    checks++; if (outst_viol - b_out !== 0) begin errors++; $display("FAIL bp_outstanding: %0d cycles above 2, expected 0", outst_viol - b_out); end
    checks++; if (rd_cnt !== 16'd10) begin errors++; $display("FAIL bp_cnt: got %0d expected 10", rd_cnt); end
  endtask

  // Writer slower than reader: FIFO repeatedly runs empty.
  task automatic test_empty_boundary();
    int b_got, b_pop, b_pe;
    start_reset();
    wr_burst = 1'b0;
    wr_div   = 3;
    b_got = got_q.size();
    b_pop = pop_total;
    b_pe  = pop_empty_viol;
    for (int i = 1; i <= 80; i++) wr_q.push_back(8'(i));
    end_reset();
    bus.I_ready = 1'b1;
    wait_got(b_got + 80, 3000);
    repeat (10) @(negedge clk);
    checks++; if (got_q.size() - b_got !== 80) begin errors++; $display("FAIL empty_count: got %0d expected 80", got_q.size() - b_got); end
    for (int i = 0; i < 80 && b_got + i < got_q.size(); i++) begin
      checks++; if (got_q[b_got + i] !== 8'(i + 1)) begin errors++; $display("FAIL empty_word%0d: got %0d expected %0d", i, got_q[b_got + i], i + 1); end
    end
    checks++; if (pop_total - b_pop !== 80) begin errors++; $display("FAIL empty_pops: got %0d expected 80", pop_total - b_pop); end
    checks++; if (pop_empty_viol - b_pe !== 0) begin errors++; $display("FAIL empty_pop_while_empty: got %0d expected 0", pop_empty_viol - b_pe); end
    checks++; if (bus.O_valid !== 1'b0) begin errors++; $display("FAIL empty_valid_after_last: got %b expected 0", bus.O_valid); end
    checks++; if (bus.O_rinc !== 1'b0) begin errors++; $display("FAIL empty_rinc_idle: got %b expected 0", bus.O_rinc); end
    checks++; if (rd_cnt !== 16'd80) begin errors++; $display("FAIL empty_cnt: got %0d expected 80", rd_cnt); end
    wr_burst = 1'b1;
  endtask

  // Flush with a buffered word and a word in flight: both are discarded.
  task automatic test_flush();
    int b_got;
    start_reset();
    wr_burst = 1'b1;
    for (int i = 1; i <= 10; i++) wr_q.push_back(8'(i));
    b_got = got_q.size();
    end_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.O_valid !== 1'b1 || bus.O_data !== 8'd1) begin errors++; $display("FAIL flush_pre_head: got valid %b data %0d expected 1 and 1", bus.O_valid, bus.O_data); end
    @(posedge clk); #1;
    bus.I_ready = 1'b1;
    @(posedge clk); #1;
    bus.I_ready = 1'b0;
    flush       = 1'b1;
    @(negedge clk);
    checks++; if (rd_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt_before: got %0d expected 1", rd_cnt); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.O_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_next: got %b expected 0", bus.O_valid); end
    checks++; if (rd_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt_kept: got %0d expected 1", rd_cnt); end
    bus.I_ready = 1'b1;
    wait_got(b_got + 8, 200);
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() - b_got !== 8) begin errors++; $display("FAIL flush_count: got %0d expected 8", got_q.size() - b_got); end
    for (int i = 0; i < 8 && b_got + i < got_q.size(); i++) begin
      checks++; if (got_q[b_got + i] !== 8'((i == 0) ? 1 : i + 3)) begin errors++; $display("FAIL flush_word%0d: got %0d expected %0d", i, got_q[b_got + i], (i == 0) ? 1 : i + 3); end
    end
    checks++; if (rd_cnt !== 16'd8) begin errors++; $display("FAIL flush_cnt_final: got %0d expected 8", rd_cnt); end
  endtask

  // Random data, writer rate and downstream readiness.
  task automatic test_random();
    logic [7:0] exp_w[$];
    int b_got, b_stab, b_out, b_pe;
    start_reset();
    wr_burst = 1'b0;
    wr_div   = int'($urandom_range(1, 4));
    b_got  = got_q.size();
    b_stab = stab_viol;
    b_out  = outst_viol;
    b_pe   = pop_empty_viol;
    for (int i = 0; i < 200; i++) begin
      exp_w.push_back(8'($urandom));
      wr_q.push_back(exp_w[i]);
    end
    end_reset();
    for (int k = 0; k < 6000 && got_q.size() < b_got + 200; k++) begin
      @(posedge clk); #1;
      bus.I_ready = ($urandom_range(0, 9) < 7);
    end
    bus.I_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() - b_got !== 200) begin errors++; $display("FAIL rnd_count: got %0d expected 200", got_q.size() - b_got); end
    for (int i = 0; i < 200 && b_got + i < got_q.size(); i++) begin
      checks++; if (got_q[b_got + i] !== exp_w[i]) begin errors++; $display("FAIL rnd_word%0d: got %0h expected %0h", i, got_q[b_got + i], exp_w[i]); end
    end
    checks++; if (rd_cnt !== 16'd200) begin errors++; $display("FAIL rnd_cnt: got %0d expected 200", rd_cnt); end
    checks++; if (stab_viol - b_stab !== 0) begin errors++; $display("FAIL rnd_stable: got %0d expected 0", stab_viol - b_stab); end
    checks++; if (outst_viol - b_out !== 0) begin errors++; $display("FAIL rnd_outstanding: got %0d expected 0", outst_viol - b_out); end
    checks++; if (pop_empty_viol - b_pe !== 0) begin errors++; $display("FAIL rnd_pop_while_empty: got %0d expected 0", pop_empty_viol - b_pe); end
`ifndef FIFO_RD_SEQ_CHK_EN
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rnd_seq_err_tied: got %b expected 0", seq_err); end
`endif
    wr_burst = 1'b1;
  endtask

  // 65535 words bring the counter to 0xFFFF, two more wrap it to 1.
  task automatic test_wrap();
    int b_got, bad;
    start_reset();
    wr_burst = 1'b1;
    b_got = got_q.size();
    for (int i = 0; i < 65535; i++) wr_q.push_back(8'(i + 1));
    end_reset();
    bus.I_ready = 1'b1;
    wait_got(b_got + 65535, 70000);
    repeat (3) @(negedge clk);
    checks++; if (rd_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_cnt_max: got %0h expected ffff", rd_cnt); end
    bad = 0;
    for (int i = 0; i < 65535; i++)
      if (b_got + i >= got_q.size() || got_q[b_got + i] !== 8'(i + 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_order: %0d bad words, expected 0", bad); end
    wr_q.push_back(8'h00);
    wr_q.push_back(8'h01);
    wait_got(b_got + 65537, 100);
    repeat (3) @(negedge clk);
    checks++; if (rd_cnt !== 16'h0001) begin errors++; $display("FAIL wrap_cnt: got %0h expected 0001", rd_cnt); end
    checks++; if (got_q.size() - b_got !== 65537) begin errors++; $display("FAIL wrap_count: got %0d expected 65537", got_q.size() - b_got); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL wrap_seq_err: got %b expected 0", seq_err); end
  endtask

`ifdef FIFO_RD_SEQ_CHK_EN
  // Gap 3->5 raises the sticky error one cycle after 5 is accepted.
  task automatic test_seq();
    logic [7:0] pat[5];
    int b_got, b_acc, b_er, rise;
    pat[0] = 8'd1; pat[1] = 8'd2; pat[2] = 8'd3; pat[3] = 8'd5; pat[4] = 8'd6;
    start_reset();
    wr_burst = 1'b1;
    for (int i = 0; i < 5; i++) wr_q.push_back(pat[i]);
    b_got = got_q.size();
    b_acc = acc_cyc_q.size();
    b_er  = erise_q.size();
    end_reset();
    bus.I_ready = 1'b1;
    wait_got(b_got + 5, 100);
    repeat (5) @(negedge clk);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_gap_err: got %b expected 1", seq_err); end
    checks++; if (erise_q.size() - b_er !== 1) begin errors++; $display("FAIL seq_gap_rises: got %0d expected 1", erise_q.size() - b_er); end
    rise = (erise_q.size() > b_er && acc_cyc_q.size() > b_acc + 3) ? erise_q[b_er] - acc_cyc_q[b_acc + 3] : -1;
    checks++; if (rise !== 1) begin errors++; $display("FAIL seq_gap_timing: got %0d expected 1", rise); end
    repeat (10) @(negedge clk);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b expected 1", seq_err); end

    start_reset();
    @(negedge clk);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_reset_clear: got %b expected 0", seq_err); end
    wr_burst = 1'b0;
    wr_div   = 2;
    b_got = got_q.size();
    b_er  = erise_q.size();
    for (int i = 1; i <= 90; i++) wr_q.push_back(8'(i));
    end_reset();
    for (int k = 0; k < 2000 && got_q.size() < b_got + 90; k++) begin
      @(posedge clk); #1;
      bus.I_ready = ($urandom_range(0, 3) != 0);
    end
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() - b_got !== 90) begin errors++; $display("FAIL seq_clean_count: got %0d expected 90", got_q.size() - b_got); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_clean_err: got %b expected 0", seq_err); end
    checks++; if (erise_q.size() - b_er !== 0) begin errors++; $display("FAIL seq_clean_rises: got %0d expected 0", erise_q.size() - b_er); end
    wr_burst = 1'b1;
  endtask
`endif

  initial begin
    bus.I_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_random();
`ifdef FIFO_RD_SEQ_CHK_EN
    test_seq();
`endif
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
